square_gen_seq: RTL
===================

Name: square_gen_seq

Overview:
- Parametrised sequential successor to the combinational squarer.
- Computes num*num with an N-cycle shift-add datapath behind valid/ready handshakes on both input and output.
- Adds an accumulate mode that returns a running sum of squares, with a clear control and a sticky overflow flag.
- Sits between an operand producer and a result consumer. Both sides may stall.

Parameters:
- N, 4, operand width in bits (N >= 2).
- ACC_W, 4, guard bits added to the square width for the accumulator. Result width OW = 2*N + ACC_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand present on num.
- in_ready  out  1  block can accept an operand.
- num  in  N  unsigned operand.
- acc_mode  in  1  sampled with num. 0 = plain square; 1 = add square to accumulator.
- acc_clear  in  1  synchronous clear of the accumulator and the overflow flag.
- out_valid  out  1  result present on out.
- out_ready  in  1  consumer accepts result.
- out  out  OW  unsigned result, zero-extended for plain square.
- ovf  out  1  sticky accumulator overflow.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out=0, ovf=0, accumulator=0, internal operand/product/count=0.
  - Reset mid-operation abandons the calculation with no partial output.
- FSM has three states.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a=num, m=num, prod=0, cnt=0 and mode=acc_mode, then go to CALC.
  - CALC: in_ready=0, out_valid=0. Each clock: if m[0], prod += a<<cnt (2N-bit add, no overflow possible); m>>=1; cnt++. When cnt==N-1 on this edge, go to DONE.
  - DONE: out_valid=1 and out stable until out_valid&&out_ready. That edge returns to IDLE.
- Result register is loaded on the CALC->DONE edge.
  - mode=0: out = zero-extend(final prod). Accumulator is untouched.
  - mode=1: sum = acc + final prod, taken modulo 2^OW. acc <= sum and out <= sum. If a carry leaves OW bits, ovf <= 1.
- Latency: handshake at edge k, then out_valid is high after edge k+N.
  - Minimum initiation interval is N+2 clocks (CALC N, DONE 1, IDLE 1).
  - in_ready is never high while busy.
- acc_clear acts in any state and clears acc and ovf on that edge.
  - If it coincides with the CALC->DONE accumulate edge, clear wins: acc=0 and ovf=0. The out value still shows the pre-clear sum.
  - out and out_valid are unaffected by clear.
- Output backpressure: with out_ready=0, hold DONE indefinitely. out must not change.
- num=0 gives 0. num=2^N-1 gives (2^N-1)^2, which fits in 2N bits.
- Plain-square results never set ovf.

Decomposition:
- Package square_gen_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - the OW width function;
  - the count width $clog2(N).
- One sub-module, square_gen_core: shift-add datapath (a, m, prod, cnt; ports load/step/done). The top keeps the FSM, handshakes, accumulator and ovf.

Test Plan:
- N=4, num=15, acc_mode=0, out_ready=1 -> out_valid rises exactly 4 clocks after accept. out=225, ovf=0. in_ready low until the cycle after the result handshake.
- Sweep num=0..15, plain mode -> out equals num*num for every value, including 0 -> 0.
- acc_clear, then acc_mode=1 with num=3 then num=4 -> outputs 9 then 25. Then acc_clear and num=2 -> output 4.
- N=4, ACC_W=1 (OW=9), accumulate 15,15,15 -> 225, 450-512=... checked as 225, then 450 mod 512=450 with ovf=0, then 675 mod 512=163 with ovf=1. ovf stays 1 until acc_clear.
- out_ready held 0 for 10 clocks in DONE -> out_valid stays 1 and out stable. in_valid with a new num is ignored (in_ready=0) until release.
- rst asserted during CALC (after 2 clocks) -> next clock IDLE, out_valid=0, out=0, acc=0. A following num=5 gives 25.

Source files
------------

// File: rtl/square_gen_pkg.sv
// Shared definitions for the sequential squarer: FSM encoding and width helpers.
package square_gen_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t DONE = 2'd2;

    // Result width: full square plus accumulator guard bits.
    function automatic int unsigned ow_width(input int unsigned n, input int unsigned acc_w);
        return 2 * n + acc_w;
    endfunction

    // Bit-position counter width; it only needs to reach N-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/square_gen_core.sv
// Shift-add squaring datapath: one partial product per step, N steps per operand.
module square_gen_core
    import square_gen_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [N-1:0]   num,
    output logic           done,
    output logic [2*N-1:0] prod,
    output logic [2*N-1:0] prod_next
);

    localparam int unsigned CW = cnt_width(N);

    logic [N-1:0]   a;
    logic [N-1:0]   m;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] addend;

    // Partial product for the current bit; prod_next includes it so the final step's
    // contribution is visible to the top on the same edge the FSM leaves CALC.
    always_comb begin
        addend    = m[0] ? ({{N{1'b0}}, a} << cnt) : '0;
        prod_next = prod + addend;
        done      = (cnt == CW'(N - 1));
    end

    // Operand, multiplier shift register, product and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a    <= '0;
            m    <= '0;
            prod <= '0;
            cnt  <= '0;
        end else if (load) begin
            a    <= num;
            m    <= num;
            prod <= '0;
            cnt  <= '0;
        end else if (step) begin
            prod <= prod_next;
            m    <= m >> 1;
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/square_gen_seq.sv
// Sequential squarer with valid/ready on both sides and an optional running sum of squares.
module square_gen_seq
    import square_gen_pkg::*;
#(
    parameter  int unsigned N     = 4,
    parameter  int unsigned ACC_W = 4,
    localparam int unsigned OW    = ow_width(N, ACC_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  num,
    input  logic          acc_mode,
    input  logic          acc_clear,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out,
    output logic          ovf
);

    state_t         state;
    state_t         state_next;
    logic           mode;
    logic [OW-1:0]  acc;
    logic [OW:0]    sum;
    logic           load;
    logic           step;
    logic           core_done;
    logic [2*N-1:0] prod;
    logic [2*N-1:0] prod_next;
    logic           finish;

    square_gen_core #(
        .N (N)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .num       (num),
        .done      (core_done),
        .prod      (prod),
        .prod_next (prod_next)
    );

    // Handshake decode and accumulator adder; sum keeps one extra bit to expose the carry.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        load      = in_valid && in_ready;
        step      = (state == CALC);
        finish    = step && core_done;
        sum       = {1'b0, acc} + (OW + 1)'(prod_next);
    end

    // Next-state logic for IDLE -> CALC -> DONE -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = CALC;
            CALC:    if (core_done) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, captured mode, result, accumulator and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mode  <= 1'b0;
            out   <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                mode <= acc_mode;
            end
            if (finish) begin
                if (mode) begin
                    out <= sum[OW-1:0];
                    acc <= sum[OW-1:0];
                    if (sum[OW]) begin
                        ovf <= 1'b1;
                    end
                end else begin
                    out <= OW'(prod_next);
                end
            end
            // Clear overrides a same-edge accumulate; out still carries the pre-clear sum.
            if (acc_clear) begin
                acc <= '0;
                ovf <= 1'b0;
            end
        end
    end

endmodule
